// File: rtl/alu_sequencer.sv
// Multi-cycle controller that steps a shared ALU through READ/EXEC/WB for each
// command, sourcing operands from and writing results to a small register file.
module alu_sequencer #(
    parameter int MAX_WIDTH = 8,
    parameter int RA_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_selop,
    input  logic [1:0]           cmd_shamt,
    input  logic [RA_W-1:0]      cmd_ra,
    input  logic [RA_W-1:0]      cmd_rb,
    input  logic [RA_W-1:0]      cmd_rd,
    input  logic                 cmd_setf,
    input  logic                 ld_en,
    input  logic [RA_W-1:0]      ld_addr,
    input  logic [MAX_WIDTH-1:0] ld_data,
    output logic [MAX_WIDTH-1:0] alu_busA,
    output logic [MAX_WIDTH-1:0] alu_busB,
    output logic [2:0]           alu_selop,
    output logic [1:0]           alu_shamt,
    output logic                 alu_enaf,
    input  logic [MAX_WIDTH-1:0] alu_busC,
    output logic                 busy,
    output logic                 done,
    output logic [MAX_WIDTH-1:0] done_data,
    input  logic [RA_W-1:0]      dbg_addr,
    output logic [MAX_WIDTH-1:0] dbg_data
);

    localparam int NREGS = 2 ** RA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t                 state;
    logic [MAX_WIDTH-1:0]   regs [NREGS];
    logic [2:0]             lat_selop;
    logic [1:0]             lat_shamt;
    logic [RA_W-1:0]        lat_ra;
    logic [RA_W-1:0]        lat_rb;
    logic [RA_W-1:0]        lat_rd;
    logic                   lat_setf;
    logic [MAX_WIDTH-1:0]   result;

    // A direct load in IDLE takes the cycle, so the command waits one more.
    assign cmd_ready = (state == IDLE) && !ld_en;
    assign dbg_data  = regs[dbg_addr];
    assign done_data = result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            lat_selop <= '0;
            lat_shamt <= '0;
            lat_ra    <= '0;
            lat_rb    <= '0;
            lat_rd    <= '0;
            lat_setf  <= 1'b0;
            result    <= '0;
            alu_busA  <= '0;
            alu_busB  <= '0;
            alu_selop <= '0;
            alu_shamt <= '0;
            alu_enaf  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_en) begin
                        regs[ld_addr] <= ld_data;
                    end else if (cmd_valid) begin
                        lat_selop <= cmd_selop;
                        lat_shamt <= cmd_shamt;
                        lat_ra    <= cmd_ra;
                        lat_rb    <= cmd_rb;
                        lat_rd    <= cmd_rd;
                        lat_setf  <= cmd_setf;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end
                // Operands are sampled here, before write-back, so an aliased rd
                // still contributes its old value.
                READ: begin
                    alu_busA  <= regs[lat_ra];
                    alu_busB  <= regs[lat_rb];
                    alu_selop <= lat_selop;
                    alu_shamt <= lat_shamt;
                    alu_enaf  <= lat_setf;
                    state     <= EXEC;
                end
                EXEC: begin
                    alu_enaf <= 1'b0;
                    result   <= alu_busC;
                    done     <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    regs[lat_rd] <= result;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
